// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch back-end: fetch state encoding,
// bubble instruction word, exception-code width and the IF/ID payload layout.
package if_fetch_unit_pkg;

    localparam int          EXCEPT_W      = 8;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // IDLE: address phase, WAIT: data pending, HOLD: data buffered while ID
    // stalls, DISCARD: swallow the one response orphaned by a flush.
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DISCARD
    } fetch_state_e;

    // One instruction as it is handed to the IF/ID register.
    typedef struct packed {
        logic [31:0]         pc;
        logic [31:0]         instr;
        logic [EXCEPT_W-1:0] except;
        logic                is_in_delayslot;
    } if_id_entry_t;

    // The instruction bus only ever sees word-aligned addresses.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a completed
// fetch, otherwise every field holds.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                load_i,
    input  if_id_entry_t        entry_i,
    output logic [31:0]         id_pc_o,
    output logic [31:0]         id_pc4_o,
    output logic [31:0]         id_instr_o,
    output logic [EXCEPT_W-1:0] id_except_o,
    output logic                id_is_in_delayslot_o,
    output logic                id_valid_o
);

    // Pipeline register with flush > load > hold priority.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            id_pc_o              <= '0;
            id_pc4_o             <= '0;
            id_instr_o           <= NOP_INSTR;
            id_except_o          <= '0;
            id_is_in_delayslot_o <= 1'b0;
            id_valid_o           <= 1'b0;
        end else if (flush_i) begin
            id_pc_o              <= '0;
            id_pc4_o             <= '0;
            id_instr_o           <= NOP_INSTR;
            id_except_o          <= '0;
            id_is_in_delayslot_o <= 1'b0;
            id_valid_o           <= 1'b0;
        end else if (load_i) begin
            id_pc_o              <= entry_i.pc;
            id_pc4_o             <= entry_i.pc + 32'd4;
            id_instr_o           <= entry_i.instr;
            id_except_o          <= entry_i.except;
            id_is_in_delayslot_o <= entry_i.is_in_delayslot;
            id_valid_o           <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch back-end: issues one request per PC on a split address/data
// instruction bus, buffers the word if ID is stalled, drops responses that a
// flush has orphaned, and feeds the IF/ID register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         if_pc_i,
    input  logic [EXCEPT_W-1:0] if_except_i,
    input  logic                if_is_in_delayslot_i,
    input  logic                if_flush_i,
    input  logic                id_stall_i,
    output logic                inst_req_o,
    output logic [31:0]         inst_addr_o,
    input  logic                inst_addr_ok_i,
    input  logic                inst_data_ok_i,
    input  logic [31:0]         inst_rdata_i,
    output logic                if_stallreq_o,
    output logic [31:0]         id_pc_o,
    output logic [31:0]         id_pc4_o,
    output logic [31:0]         id_instr_o,
    output logic [EXCEPT_W-1:0] id_except_o,
    output logic                id_is_in_delayslot_o,
    output logic                id_valid_o
);

    fetch_state_e state;
    logic [31:0]  hold_word;
    logic         fetch_done;
    logic [31:0]  fetch_instr;
    logic         id_load;
    if_id_entry_t entry;

    // Address phase is only open in IDLE; a flush gates it so a same-cycle
    // addr_ok can never start a transaction.
    assign inst_req_o  = (state == FETCH_IDLE) && !if_flush_i && (if_except_i == '0);
    assign inst_addr_o = word_align(if_pc_i);

    // Decide whether the current PC has its instruction word this cycle.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        fetch_done  = 1'b0;
        fetch_instr = NOP_INSTR;
        case (state)
            FETCH_IDLE: fetch_done = (if_except_i != '0);
            FETCH_WAIT: begin
                fetch_done  = inst_data_ok_i;
                fetch_instr = inst_rdata_i;
            end
            FETCH_HOLD: begin
                fetch_done  = 1'b1;
                fetch_instr = hold_word;
            end
            default: ;
        endcase
    end

    assign if_stallreq_o = !(fetch_done && !id_stall_i) && !if_flush_i;
    assign id_load       = fetch_done && !id_stall_i && !if_flush_i;

    assign entry.pc              = if_pc_i;
    assign entry.instr           = fetch_instr;
    assign entry.except          = if_except_i;
    assign entry.is_in_delayslot = if_is_in_delayslot_i;

    // Fetch FSM; a flush overrides every other transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= FETCH_IDLE;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (inst_req_o && inst_addr_ok_i) state <= FETCH_WAIT;
                end
                FETCH_WAIT: begin
                    if (if_flush_i)          state <= inst_data_ok_i ? FETCH_IDLE : FETCH_DISCARD;
                    else if (inst_data_ok_i) state <= id_stall_i ? FETCH_HOLD : FETCH_IDLE;
                end
                FETCH_HOLD: begin
                    if (if_flush_i || !id_stall_i) state <= FETCH_IDLE;
                end
                FETCH_DISCARD: begin
                    // A flush keeps us here, but the orphaned response still
                    // ends the transaction; nothing else could release us.
                    if (inst_data_ok_i) state <= FETCH_IDLE;
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    // Capture the word when it arrives while ID is stalled.
    // NOTE: the buffer is data-only and is read solely in HOLD, which is only
    // entered on the cycle it is written, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (state == FETCH_WAIT && inst_data_ok_i && id_stall_i && !if_flush_i)
            hold_word <= inst_rdata_i;
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .flush_i              (if_flush_i),
        .load_i               (id_load),
        .entry_i              (entry),
        .id_pc_o              (id_pc_o),
        .id_pc4_o             (id_pc4_o),
        .id_instr_o           (id_instr_o),
        .id_except_o          (id_except_o),
        .id_is_in_delayslot_o (id_is_in_delayslot_o),
        .id_valid_o           (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic [7:0]  if_except_i;
    logic        if_is_in_delayslot_i;
    logic        if_flush_i;
    logic        id_stall_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        if_stallreq_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [31:0] id_instr_o;
    logic [7:0]  id_except_o;
    logic        id_is_in_delayslot_o;
    logic        id_valid_o;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_unit dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .if_pc_i              (if_pc_i),
        .if_except_i          (if_except_i),
        .if_is_in_delayslot_i (if_is_in_delayslot_i),
        .if_flush_i           (if_flush_i),
        .id_stall_i           (id_stall_i),
        .inst_req_o           (inst_req_o),
        .inst_addr_o          (inst_addr_o),
        .inst_addr_ok_i       (inst_addr_ok_i),
        .inst_data_ok_i       (inst_data_ok_i),
        .inst_rdata_i         (inst_rdata_i),
        .if_stallreq_o        (if_stallreq_o),
        .id_pc_o              (id_pc_o),
        .id_pc4_o             (id_pc4_o),
        .id_instr_o           (id_instr_o),
        .id_except_o          (id_except_o),
        .id_is_in_delayslot_o (id_is_in_delayslot_o),
        .id_valid_o           (id_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Memory image seen by the bus slave in the random run.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [105:0] id_bundle_of(input logic [31:0] pc, input logic [31:0] instr,
                                                  input logic [7:0] exc, input logic ds);
        return {pc, pc + 32'd4, instr, exc, ds, 1'b1};
    endfunction

    logic [105:0] id_bundle;
    assign id_bundle = {id_pc_o, id_pc4_o, id_instr_o, id_except_o, id_is_in_delayslot_o, id_valid_o};

    localparam logic [105:0] BUBBLE = {32'h0, 32'h0, NOP, 8'h0, 1'b0, 1'b0};

    // Reference-model state for the random run.
    logic [105:0] exp_id;
    bit           out_valid;
    int unsigned  out_epoch;
    logic [31:0]  out_addr;
    int           out_cnt;
    bit           have_data;
    int unsigned  epoch;
    bit           cur_data, done, exp_req, exp_stall, do_load;
    logic [31:0]  nxt_pc;
    logic [7:0]   nxt_exc;
    logic         nxt_ds;
    bit           advance;

    initial begin
        rst_i                = 1'b1;
        if_pc_i              = 32'h0000_0100;
        if_except_i          = 8'h00;
        if_is_in_delayslot_i = 1'b0;
        if_flush_i           = 1'b0;
        id_stall_i           = 1'b0;
        inst_addr_ok_i       = 1'b0;
        inst_data_ok_i       = 1'b0;
        inst_rdata_i         = 32'h0;

        // ---- 1: reset values, reset mid-WAIT, late data_ok ignored
        #12;
        check("reset_id", id_bundle, BUBBLE);
        check("reset_req", inst_req_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        inst_addr_ok_i = 1'b1;
        @(negedge clk_i);
        check("t1_req", inst_req_o, 1'b1);
        tick();
        inst_addr_ok_i = 1'b0;
        check("t1_wait_req", inst_req_o, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check("t1_rst_valid", id_valid_o, 1'b0);
        check("t1_rst_req", inst_req_o, 1'b1);
        tick();
        rst_i          = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h1111_1111;
        @(negedge clk_i);
        check("t1_late_stall", if_stallreq_o, 1'b1);
        tick();
        inst_data_ok_i = 1'b0;
        check("t1_late_valid", id_valid_o, 1'b0);
        check("t1_late_instr", id_instr_o, NOP);

        // ---- 2: basic fetch, 2-cycle throughput
        if_pc_i        = 32'hBFC0_0000;
        inst_addr_ok_i = 1'b1;
        @(negedge clk_i);
        check("t2_req", inst_req_o, 1'b1);
        check("t2_addr", inst_addr_o, 32'hBFC0_0000);
        check("t2_stall_c0", if_stallreq_o, 1'b1);
        tick();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2408_0001;
        @(negedge clk_i);
        check("t2_stall_c1", if_stallreq_o, 1'b0);
        tick();
        inst_data_ok_i = 1'b0;
        check("t2_id", id_bundle, id_bundle_of(32'hBFC0_0000, 32'h2408_0001, 8'h00, 1'b0));

        // ---- 3: data arrives while ID is stalled, released after 3 cycles
        if_pc_i        = 32'hBFC0_0004;
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h3C1D_8000;
        id_stall_i     = 1'b1;
        @(negedge clk_i);
        check("t3_stall_c1", if_stallreq_o, 1'b1);
        tick();
        inst_data_ok_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inst_rdata_i = $urandom;
            @(negedge clk_i);
            check("t3_hold_stall", if_stallreq_o, 1'b1);
            check("t3_hold_req", inst_req_o, 1'b0);
            tick();
            check("t3_hold_id", id_bundle, id_bundle_of(32'hBFC0_0000, 32'h2408_0001, 8'h00, 1'b0));
        end
        id_stall_i = 1'b0;
        @(negedge clk_i);
        check("t3_release_stall", if_stallreq_o, 1'b0);
        tick();
        check("t3_release_id", id_bundle, id_bundle_of(32'hBFC0_0004, 32'h3C1D_8000, 8'h00, 1'b0));

        // ---- 4: flush in WAIT, orphaned response dropped
        if_pc_i        = 32'hBFC0_0008;
        inst_addr_ok_i = 1'b1;
        tick();
        inst_addr_ok_i = 1'b0;
        if_flush_i     = 1'b1;
        @(negedge clk_i);
        check("t4_flush_stall", if_stallreq_o, 1'b0);
        tick();
        check("t4_bubble", id_bundle, BUBBLE);
        if_flush_i = 1'b0;
        if_pc_i    = 32'h8000_0180;
        @(negedge clk_i);
        check("t4_discard_req", inst_req_o, 1'b0);
        check("t4_discard_stall", if_stallreq_o, 1'b1);
        tick();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("t4_orphan_stall", if_stallreq_o, 1'b1);
        tick();
        inst_data_ok_i = 1'b0;
        check("t4_orphan_id", id_bundle, BUBBLE);
        inst_addr_ok_i = 1'b1;
        @(negedge clk_i);
        check("t4_new_req", inst_req_o, 1'b1);
        check("t4_new_addr", inst_addr_o, 32'h8000_0180);
        tick();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h0000_000C;
        tick();
        inst_data_ok_i = 1'b0;
        check("t4_new_id", id_bundle, id_bundle_of(32'h8000_0180, 32'h0000_000C, 8'h00, 1'b0));

        // ---- 5: excepting fetch completes in one cycle without bus access
        if_pc_i              = 32'h0000_0002;
        if_except_i          = 8'h80;
        if_is_in_delayslot_i = 1'b1;
        inst_addr_ok_i       = 1'b1;
        @(negedge clk_i);
        check("t5_req", inst_req_o, 1'b0);
        check("t5_stall", if_stallreq_o, 1'b0);
        tick();
        check("t5_id", id_bundle, id_bundle_of(32'h0000_0002, NOP, 8'h80, 1'b1));
        // PC+4 wraps at the top of the address space
        if_pc_i              = 32'hFFFF_FFFC;
        if_except_i          = 8'h01;
        if_is_in_delayslot_i = 1'b0;
        tick();
        inst_addr_ok_i = 1'b0;
        check("t5_wrap_pc4", id_pc4_o, 32'h0000_0000);
        check("t5_wrap_exc", id_except_o, 8'h01);

        // ---- 6: randomized run against the reference model
        exp_id    = BUBBLE;
        out_valid = 0;
        out_cnt   = 0;
        out_epoch = 0;
        out_addr  = '0;
        have_data = 0;
        epoch     = 0;
        if_except_i = 8'h00;
        if_pc_i     = 32'h0000_1000;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if_flush_i     = (cyc == 0) || ($urandom_range(0, 24) == 0);
            id_stall_i     = ($urandom_range(0, 3) == 0);
            inst_addr_ok_i = $urandom_range(0, 1) == 1;
            if (out_valid && out_cnt == 0) begin
                inst_data_ok_i = 1'b1;
                inst_rdata_i   = mem_word(out_addr);
            end else begin
                inst_data_ok_i = 1'b0;
                inst_rdata_i   = $urandom;
            end

            @(negedge clk_i);
            // The current PC is complete once its word has arrived (now or
            // earlier), or immediately if it excepts and the bus is idle.
            cur_data  = inst_data_ok_i && out_valid && (out_epoch == epoch);
            done      = ((if_except_i != 8'h00) && !out_valid) || have_data || cur_data;
            exp_req   = !if_flush_i && (if_except_i == 8'h00) && !out_valid && !have_data;
            exp_stall = !(done && !id_stall_i) && !if_flush_i;
            check("rnd_req", inst_req_o, exp_req);
            if (exp_req) check("rnd_addr", inst_addr_o, {if_pc_i[31:2], 2'b00});
            check("rnd_stallreq", if_stallreq_o, exp_stall);

            do_load = !if_flush_i && done && !id_stall_i;
            if (if_flush_i)
                exp_id = BUBBLE;
            else if (do_load)
                exp_id = id_bundle_of(if_pc_i,
                                      (if_except_i != 8'h00) ? NOP : mem_word({if_pc_i[31:2], 2'b00}),
                                      if_except_i, if_is_in_delayslot_i);
            if (cur_data && id_stall_i && !if_flush_i) have_data = 1;
            if (inst_data_ok_i) out_valid = 0;
            else if (out_valid) out_cnt--;
            if (exp_req && inst_addr_ok_i) begin
                out_valid = 1;
                out_epoch = epoch;
                out_addr  = {if_pc_i[31:2], 2'b00};
                out_cnt   = $urandom_range(0, 5);
            end
            advance = if_flush_i || do_load;
            if (advance) begin
                epoch++;
                have_data = 0;
                nxt_pc    = (if_flush_i || $urandom_range(0, 4) == 0) ? $urandom : if_pc_i + 32'd4;
                nxt_exc   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                if (nxt_exc == 8'h00) nxt_pc = {nxt_pc[31:2], 2'b00};
                nxt_ds    = $urandom_range(0, 1) == 1;
            end

            tick();
            check("rnd_id", id_bundle, exp_id);
            if (advance) begin
                if_pc_i              = nxt_pc;
                if_except_i          = nxt_exc;
                if_is_in_delayslot_i = nxt_ds;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
